// File: rtl/cal_pulse_sched.sv
// rtl/cal_pulse_sched.sv - calibration pulse burst sequencer with trigger requests
// Whole state (FSM, counters, latched config, registered outputs) optionally triplicated and voted.
module cal_pulse_sched #(
  parameter int TMR = 0
) (
  input  logic        CLK40,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic        SEL_EXT,
  input  logic [11:0] NPULSE,
  input  logic [7:0]  DELAY,
  input  logic [3:0]  WIDTH,
  input  logic [15:0] PERIOD,
  input  logic [7:0]  TRG_LAT,
  output logic        INJ_REQ,
  output logic        EXT_REQ,
  output logic        TRG_REQ,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVR,
  output logic [11:0] SENT_CNT
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DLY   = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    FLUSH = 3'd4
  } state_t;

  typedef struct packed {
    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  trg_cnt;
    logic        trg_pend;
    logic        sel;
    logic [11:0] npulse;
    logic [3:0]  width;
    logic [15:0] spacing;
    logic [7:0]  lat;
    logic [11:0] sent;
    logic        inj;
    logic        ext;
    logic        trg;
    logic        busy;
    logic        done;
    logic        ovr;
  } st_t;

  localparam int SW = $bits(st_t);

  st_t         q;
  st_t         n;
  logic        rise;
  logic        finish;
  logic [15:0] w2;

  assign w2 = {12'd0, WIDTH} + 16'd2;

  generate
    if (TMR != 0) begin : g_tmr
      logic [SW-1:0] r0;
      logic [SW-1:0] r1;
      logic [SW-1:0] r2;
      always_ff @(posedge CLK40) begin
        if (!RST_N) begin
          r0 <= '0;
          r1 <= '0;
          r2 <= '0;
        end else begin
          r0 <= n;
          r1 <= n;
          r2 <= n;
        end
      end
      assign q = st_t'((r0 & r1) | (r0 & r2) | (r1 & r2));
    end else begin : g_single
      logic [SW-1:0] r0;
      always_ff @(posedge CLK40) begin
        if (!RST_N) begin
          r0 <= '0;
        end else begin
          r0 <= n;
        end
      end
      assign q = st_t'(r0);
    end
  endgenerate

  always_comb begin
    n      = q;
    n.trg  = 1'b0;
    n.done = 1'b0;
    rise   = 1'b0;
    finish = 1'b0;

    if (q.trg_pend) begin
      if (q.trg_cnt == 8'd0) begin
        n.trg      = 1'b1;
        n.trg_pend = 1'b0;
      end else begin
        n.trg_cnt = q.trg_cnt - 8'd1;
      end
    end

    case (q.state)
      IDLE: begin
        if (START && !ABORT && (NPULSE != 12'd0)) begin
          n.sel      = SEL_EXT;
          n.npulse   = NPULSE;
          n.width    = WIDTH;
          n.lat      = TRG_LAT;
          n.spacing  = (PERIOD > w2) ? PERIOD : w2;
          n.sent     = 12'd0;
          n.ovr      = 1'b0;
          n.busy     = 1'b1;
          n.trg_pend = 1'b0;
          if (DELAY == 8'd0) begin
            rise = 1'b1;
          end else begin
            n.state = DLY;
            n.cnt   = {8'd0, DELAY} - 16'd1;
          end
        end
      end
      DLY: begin
        if (q.cnt == 16'd0) begin
          rise = 1'b1;
        end else begin
          n.cnt = q.cnt - 16'd1;
        end
      end
      PULSE: begin
        n.cnt = q.cnt + 16'd1;
        if (q.cnt >= {12'd0, q.width}) begin
          n.inj = 1'b0;
          n.ext = 1'b0;
          if (q.sent == q.npulse) begin
            // a trigger still counting down keeps the burst open until it fires
            if (q.trg_pend) begin
              n.state = FLUSH;
            end else begin
              finish = 1'b1;
            end
          end else begin
            n.state = GAP;
          end
        end
      end
      GAP: begin
        if (q.cnt == q.spacing - 16'd1) begin
          rise = 1'b1;
        end else begin
          n.cnt = q.cnt + 16'd1;
        end
      end
      FLUSH: begin
        if (!q.trg_pend) begin
          finish = 1'b1;
        end
      end
      default: begin
        n.state = IDLE;
      end
    endcase

    if (rise) begin
      n.state = PULSE;
      n.cnt   = 16'd0;
      n.inj   = ~n.sel;
      n.ext   = n.sel;
      n.sent  = n.sent + 12'd1;
      // a trigger still pending at a new rising edge is dropped
      if (q.trg_pend) begin
        n.ovr = 1'b1;
      end
      if (n.lat == 8'd0) begin
        n.trg      = 1'b1;
        n.trg_pend = 1'b0;
      end else begin
        n.trg      = 1'b0;
        n.trg_pend = 1'b1;
        n.trg_cnt  = n.lat - 8'd1;
      end
    end

    if (finish) begin
      n.state = IDLE;
      n.done  = 1'b1;
      n.busy  = 1'b0;
    end

    if (ABORT && (q.state != IDLE)) begin
      n.state    = IDLE;
      n.inj      = 1'b0;
      n.ext      = 1'b0;
      n.trg      = 1'b0;
      n.busy     = 1'b0;
      n.done     = 1'b0;
      n.trg_pend = 1'b0;
    end
  end

  assign INJ_REQ  = q.inj;
  assign EXT_REQ  = q.ext;
  assign TRG_REQ  = q.trg;
  assign BUSY     = q.busy;
  assign DONE     = q.done;
  assign OVR      = q.ovr;
  assign SENT_CNT = q.sent;

endmodule
